// File: rtl/systolic_matmul_core.sv
// systolic_matmul_core: N x N output-stationary systolic matrix multiplier, C = A x B.
// A is N x K and B is K x N. Operands arrive as K handshaked beats. Beat k carries column k of A
// and row k of B. Operand skew, pipeline flush and row-by-row result drain are all internal.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   start, k_len     start pulse (honoured only in idle) and inner dimension K
//   busy             high from accepted start until done
//   in_valid/ready   operand beat handshake; a_col[i] = A[i][k], b_row[j] = B[k][j]
//   out_valid/ready  result row handshake; out_row indexes the row shown on out_data
//   done             one-cycle pulse after the last row handshake
//   sat_flag         (SYSTOLIC_SATURATE_EN only) per-column sticky saturation flag of out_row
//
// Optional macro SYSTOLIC_SATURATE_EN: saturating accumulators and the sat_flag port.
// Without it, accumulation wraps modulo 2^ACC_WIDTH.
module systolic_matmul_core #(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned K_WIDTH    = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic [K_WIDTH-1:0]                  k_len,
  output logic                                busy,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [N*DATA_WIDTH-1:0]             a_col,
  input  logic [N*DATA_WIDTH-1:0]             b_row,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_row,
  output logic [N*ACC_WIDTH-1:0]              out_data,
`ifdef SYSTOLIC_SATURATE_EN
  output logic [N-1:0]                        sat_flag,
`endif
  output logic                                done
);

  localparam int unsigned RowW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned FlushW = $clog2(2 * N);
  // Deepest PE sits 2N-2 hops from the array edge; one more cycle for its accumulate.
  localparam logic [FlushW-1:0] FlushLast = FlushW'(2 * N - 2);

  typedef enum logic [1:0] {StIdle, StFeed, StFlush, StDrain} state_e;

  state_e              state_q, state_d;
  logic [K_WIDTH-1:0]  k_len_q, beat_cnt_q;
  logic [FlushW-1:0]   flush_cnt_q;
  logic [RowW-1:0]     row_q;
  logic                done_q;

  logic start_acc, beat_acc, last_beat, flush_end, row_hs, last_row, accum_en;

  // ---------------------------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------------------------
  // done_q is only high in the first idle cycle; a start there is dropped.
  assign start_acc = start && (state_q == StIdle) && !done_q;
  assign beat_acc  = in_valid && in_ready;
  assign last_beat = (beat_cnt_q + K_WIDTH'(1)) == k_len_q;
  assign flush_end = (state_q == StFlush) && (flush_cnt_q == FlushLast);
  assign row_hs    = out_valid && out_ready;
  assign last_row  = row_q == RowW'(N - 1);
  assign accum_en  = (state_q == StFeed) || (state_q == StFlush);

  assign busy      = state_q != StIdle;
  assign in_ready  = state_q == StFeed;
  assign out_valid = state_q == StDrain;
  assign out_row   = row_q;
  assign done      = done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start_acc) state_d = (k_len == '0) ? StFlush : StFeed;
      StFeed:  if (beat_acc && last_beat) state_d = StFlush;
      StFlush: if (flush_end) state_d = StDrain;
      StDrain: if (row_hs && last_row) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      k_len_q     <= '0;
      beat_cnt_q  <= '0;
      flush_cnt_q <= '0;
      row_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= row_hs && last_row;
      if (start_acc) begin
        k_len_q    <= k_len;
        beat_cnt_q <= '0;
      end else if (beat_acc) begin
        beat_cnt_q <= beat_cnt_q + K_WIDTH'(1);
      end
      if (state_q != StFlush) flush_cnt_q <= '0;
      else                    flush_cnt_q <= flush_cnt_q + FlushW'(1);
      if (row_hs) row_q <= last_row ? '0 : row_q + RowW'(1);
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Edge injection and skew: bubbles inject zeros, row/column i is delayed by i registers
  // ---------------------------------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0] a_feed [N];
  logic signed [DATA_WIDTH-1:0] b_feed [N];
  logic signed [DATA_WIDTH-1:0] a_edge [N];
  logic signed [DATA_WIDTH-1:0] b_edge [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_feed[i] = beat_acc ? a_col[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      b_feed[i] = beat_acc ? b_row[i*DATA_WIDTH +: DATA_WIDTH] : '0;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_edge[i] = a_feed[i];
      assign b_edge[i] = b_feed[i];
    end else begin : g_sr
      logic signed [DATA_WIDTH-1:0] a_sr_q [i];
      logic signed [DATA_WIDTH-1:0] b_sr_q [i];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int s = 0; s < i; s++) begin
            a_sr_q[s] <= '0;
            b_sr_q[s] <= '0;
          end
        end else begin
          a_sr_q[0] <= a_feed[i];
          b_sr_q[0] <= b_feed[i];
          for (int s = 1; s < i; s++) begin
            a_sr_q[s] <= a_sr_q[s-1];
            b_sr_q[s] <= b_sr_q[s-1];
          end
        end
      end
      assign a_edge[i] = a_sr_q[i-1];
      assign b_edge[i] = b_sr_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------------------------
  // PE grid: a flows right, b flows down, product registered then accumulated
  // ---------------------------------------------------------------------------------------------
  logic signed [DATA_WIDTH-1:0] a_fwd [N][N];
  logic signed [DATA_WIDTH-1:0] b_fwd [N][N];
  logic signed [ACC_WIDTH-1:0]  acc_w [N][N];
`ifdef SYSTOLIC_SATURATE_EN
  logic                         sat_w [N][N];
`endif

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_pe
      logic signed [DATA_WIDTH-1:0]   a_in, b_in, a_q, b_q;
      logic signed [2*DATA_WIDTH-1:0] prod;
      logic signed [ACC_WIDTH-1:0]    p_q, acc_q, acc_next;

      if (j == 0) begin : g_a_edge
        assign a_in = a_edge[i];
      end else begin : g_a_hop
        assign a_in = a_fwd[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in = b_edge[j];
      end else begin : g_b_hop
        assign b_in = b_fwd[i-1][j];
      end

      assign prod = a_in * b_in;

`ifdef SYSTOLIC_SATURATE_EN
      logic                       sat_q, ovf;
      logic signed [ACC_WIDTH:0]  sum_wide;
      assign sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {p_q[ACC_WIDTH-1], p_q};
      // Overflow when the carry-out sign disagrees with the result sign.
      assign ovf      = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
      assign acc_next = !ovf ? sum_wide[ACC_WIDTH-1:0] :
                        sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                            : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      assign sat_w[i][j] = sat_q;
`else
      assign acc_next = acc_q + p_q;
`endif

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q   <= '0;
          b_q   <= '0;
          p_q   <= '0;
          acc_q <= '0;
`ifdef SYSTOLIC_SATURATE_EN
          sat_q <= 1'b0;
`endif
        end else begin
          a_q <= a_in;
          b_q <= b_in;
          p_q <= ACC_WIDTH'(prod);
          if (start_acc) begin
            acc_q <= '0;
`ifdef SYSTOLIC_SATURATE_EN
            sat_q <= 1'b0;
`endif
          end else if (accum_en) begin
            acc_q <= acc_next;
`ifdef SYSTOLIC_SATURATE_EN
            sat_q <= sat_q | ovf;
`endif
          end
        end
      end

      assign a_fwd[i][j] = a_q;
      assign b_fwd[i][j] = b_q;
      assign acc_w[i][j] = acc_q;
    end
  end

  // Accumulators are frozen outside feed/flush, so the drained row holds while stalled.
  always_comb begin
    out_data = '0;
`ifdef SYSTOLIC_SATURATE_EN
    sat_flag = '0;
`endif
    if (state_q == StDrain) begin
      for (int j = 0; j < N; j++) begin
        out_data[j*ACC_WIDTH +: ACC_WIDTH] = acc_w[row_q][j];
`ifdef SYSTOLIC_SATURATE_EN
        sat_flag[j] = sat_w[row_q][j];
`endif
      end
    end
  end

endmodule
